// File: rtl/mem_port_arbiter_if.sv
// Shared memory port arbiter bundle: requester handshakes
// plus the memory-side controls driven by the arbiter.
interface mem_port_arbiter_if;
  logic req0;
  logic req1;
  logic we1;
  logic mem_sel;
  logic mem_en;
  logic mem_we;
  logic done0;
  logic done1;
  logic busy;

  modport master (
    output req0, req1, we1,
    input  mem_sel, mem_en, mem_we,
    input  done0, done1, busy
  );

  modport slave (
    input  req0, req1, we1,
    output mem_sel, mem_en, mem_we,
    output done0, done1, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single 32-bit memory port: fetch
// (0) vs load/store (1), fixed-latency access, done pulse.
module mem_port_arbiter #(
  parameter int unsigned LAT = 2
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic       en_q, en_d;
  logic       we_q, we_d;
  logic       d0_q, d0_d;
  logic       d1_q, d1_d;
  logic       busy_q, busy_d;
  logic       last_q, last_d;
  logic       win;

  // On a tie the requester that did not win last time goes next.
  assign win = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    we_d    = we_q;
    d0_d    = 1'b0;
    d1_d    = 1'b0;
    busy_d  = busy_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_d = ACCESS;
          sel_d   = win;
          en_d    = 1'b1;
          we_d    = win & bus.we1;
          last_d  = win;
          cnt_d   = LAT_M1;
          busy_d  = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
          en_d    = 1'b0;
          we_d    = 1'b0;
          d0_d    = ~sel_q;
          d1_d    = sel_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      we_q    <= we_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign bus.mem_sel = sel_q;
  assign bus.mem_en  = en_q;
  assign bus.mem_we  = we_q;
  assign bus.done0   = d0_q;
  assign bus.done1   = d1_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: four arbiters (LAT 1..4) checked every cycle against a
// timestamp model, plus directed literal expectations.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic r0 [4];
  logic r1 [4];
  logic w1 [4];
  logic sel_o [4];
  logic en_o [4];
  logic we_o [4];
  logic d0_o [4];
  logic d1_o [4];
  logic bz_o [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gi
    mem_port_arbiter_if bus ();
    mem_port_arbiter #(.LAT(g + 1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.req0 = r0[g];
    assign bus.req1 = r1[g];
    assign bus.we1  = w1[g];
    assign sel_o[g] = bus.mem_sel;
    assign en_o[g]  = bus.mem_en;
    assign we_o[g]  = bus.mem_we;
    assign d0_o[g]  = bus.done0;
    assign d1_o[g]  = bus.done1;
    assign bz_o[g]  = bus.busy;
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  // Model: a transaction is just its grant edge, winner and write flag.
  int n_edge = 0;
  int last_edge = 0;
  bit mvalid = 1'b0;
  int g_at [4];
  int free_at [4];
  bit m_last [4];
  bit m_sel [4];
  bit m_w [4];
  bit m_wv [4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        g_at[k] = -1;
        free_at[k] = n_edge + 1;
        m_last[k] = 1'b1;
        m_sel[k] = 1'b0;
        m_w[k] = 1'b0;
        m_wv[k] = 1'b0;
      end else if (mvalid && n_edge >= free_at[k] && (r0[k] || r1[k])) begin
        if (r0[k] && r1[k]) m_w[k] = !m_last[k];
        else m_w[k] = r1[k];
        m_wv[k] = m_w[k] && w1[k];
        m_last[k] = m_w[k];
        m_sel[k] = m_w[k];
        g_at[k] = n_edge;
        free_at[k] = n_edge + (k + 1) + 2;
      end
    end
    if (rst) mvalid = 1'b1;
    last_edge = n_edge;
    n_edge++;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < 4; k++) begin
        int lat;
        bit act, e_en, e_dn, e_bz;
        lat = k + 1;
        act = (g_at[k] >= 0) && (last_edge >= g_at[k]);
        e_en = act && (last_edge < g_at[k] + lat);
        e_dn = act && (last_edge == g_at[k] + lat);
        e_bz = act && (last_edge <= g_at[k] + lat);
        chk($sformatf("m%0d_sel", k), sel_o[k], m_sel[k]);
        chk($sformatf("m%0d_en", k), en_o[k], e_en);
        chk($sformatf("m%0d_we", k), we_o[k], e_en && m_wv[k]);
        chk($sformatf("m%0d_done0", k), d0_o[k], e_dn && !m_w[k]);
        chk($sformatf("m%0d_done1", k), d1_o[k], e_dn && m_w[k]);
        chk($sformatf("m%0d_busy", k), bz_o[k], e_bz);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r0[k] = 1'b0;
      r1[k] = 1'b0;
      w1[k] = 1'b0;
    end
    @(negedge clk);
    step();
    // reset state
    chk("rst_en", en_o[1], 1'b0);
    chk("rst_sel", sel_o[1], 1'b0);
    chk("rst_busy", bz_o[1], 1'b0);
    chk("rst_done0", d0_o[1], 1'b0);
    chk("rst_done1", d1_o[1], 1'b0);
    rst = 1'b0;

    // tie after reset goes to requester 0
    r0[1] = 1'b1; r1[1] = 1'b1;
    step();
    chk("tie_sel", sel_o[1], 1'b0);
    chk("tie_en", en_o[1], 1'b1);
    step();
    step();
    chk("tie_done0", d0_o[1], 1'b1);
    r0[1] = 1'b0; r1[1] = 1'b0;
    step();
    step();

    // single read, LAT=2
    r0[1] = 1'b1;
    step();
    chk("rd_c1_en", en_o[1], 1'b1);
    chk("rd_c1_sel", sel_o[1], 1'b0);
    step();
    chk("rd_c2_en", en_o[1], 1'b1);
    step();
    chk("rd_c3_en", en_o[1], 1'b0);
    chk("rd_c3_done0", d0_o[1], 1'b1);
    chk("rd_c3_done1", d1_o[1], 1'b0);
    r0[1] = 1'b0;
    step();
    chk("rd_c4_busy", bz_o[1], 1'b0);
    chk("rd_c4_done0", d0_o[1], 1'b0);
    step();

    // write, LAT=2, we1 dropped after grant
    r1[1] = 1'b1; w1[1] = 1'b1;
    step();
    chk("wr_c1_sel", sel_o[1], 1'b1);
    chk("wr_c1_we", we_o[1], 1'b1);
    w1[1] = 1'b0;
    step();
    chk("wr_c2_we", we_o[1], 1'b1);
    step();
    chk("wr_c3_done1", d1_o[1], 1'b1);
    chk("wr_c3_we", we_o[1], 1'b0);
    r1[1] = 1'b0;
    step();
    step();

    // contention, LAT=3: grants alternate with a 5-cycle period
    r0[2] = 1'b1; r1[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("ct_done0_%0d", i), d0_o[2], (i == 3) || (i == 13));
      chk($sformatf("ct_done1_%0d", i), d1_o[2], (i == 8) || (i == 18));
      if (i % 5 == 0)
        chk($sformatf("ct_sel_%0d", i), sel_o[2], (i % 10) == 5);
    end
    r0[2] = 1'b0; r1[2] = 1'b0;
    step();
    step();

    // mid-access reset, LAT=4
    r1[3] = 1'b1;
    step();
    chk("mr_sel", sel_o[3], 1'b1);
    step();
    rst = 1'b1; r1[3] = 1'b0;
    step();
    chk("mr_en", en_o[3], 1'b0);
    chk("mr_busy", bz_o[3], 1'b0);
    chk("mr_done1", d1_o[3], 1'b0);
    chk("mr_sel0", sel_o[3], 1'b0);
    rst = 1'b0;
    r0[3] = 1'b1; r1[3] = 1'b1;
    step();
    chk("mr_tie_sel", sel_o[3], 1'b0);
    chk("mr_tie_en", en_o[3], 1'b1);
    repeat (3) step();
    step();
    chk("mr_tie_done0", d0_o[3], 1'b1);
    r0[3] = 1'b0; r1[3] = 1'b0;
    step();
    step();

    // request dropped mid-access, LAT=2
    r0[1] = 1'b1;
    step();
    r0[1] = 1'b0;
    step();
    step();
    chk("dr_done0", d0_o[1], 1'b1);
    step();
    step();
    chk("dr_idle_en", en_o[1], 1'b0);
    chk("dr_idle_busy", bz_o[1], 1'b0);

    // LAT=1 write
    r1[0] = 1'b1; w1[0] = 1'b1;
    step();
    chk("l1_en", en_o[0], 1'b1);
    chk("l1_we", we_o[0], 1'b1);
    step();
    chk("l1_done1", d1_o[0], 1'b1);
    chk("l1_en_off", en_o[0], 1'b0);
    r1[0] = 1'b0; w1[0] = 1'b0;
    step();
    chk("l1_busy", bz_o[0], 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter/sequencer for the processor's single shared 32-bit memory port. Requester 0 is instruction fetch; requester 1 is load/store. The block decides which requester owns the port and drives the select of the existing 32-bit 2:1 address/write-data mux in front of memory (sel=0 → a0 = fetch, sel=1 → a1 = load/store). It also times a fixed-latency access and returns a one-cycle completion pulse to the winning requester.

Parameters:
LAT, 2, memory access latency in cycles while mem_en is held; legal range 1..255.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous reset, active-high
req0  input  1  fetch request; held high until done0
req1  input  1  load/store request; held high until done1
we1  input  1  write qualifier for requester 1; sampled only at grant
mem_sel  output  1  drives the select of the address/wdata mux; 0 = requester 0, 1 = requester 1
mem_en  output  1  memory enable, high for the whole access phase
mem_we  output  1  memory write enable, valid while mem_en is high
done0  output  1  one-cycle completion pulse to requester 0
done1  output  1  one-cycle completion pulse to requester 1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at an edge, regardless of state):
  - Go to IDLE.
  - mem_sel=0, mem_en=0, mem_we=0, done0=0, done1=0, busy=0.
  - Counter cleared; last_gnt=1, so the first tie goes to requester 0.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - Requests are sampled only in this state.
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester not equal to last_gnt (round-robin).
  - On grant, at the same edge: mem_sel=winner, mem_en=1, mem_we=(winner==1 ? we1 : 0), last_gnt=winner, cnt=LAT-1, busy=1, next state ACCESS.
- ACCESS:
  - mem_sel, mem_en and mem_we are held constant.
  - cnt decrements each cycle.
  - When cnt==0: next state RESP, mem_en=0, mem_we=0, done[mem_sel]=1.
- RESP:
  - Lasts exactly one cycle; done pulse high for this cycle only.
  - mem_sel is held through RESP.
  - Next state IDLE; done=0, busy=0.
- Timing: request seen at edge E gives mem_en high for exactly LAT cycles starting at E, done high in cycle E+LAT, IDLE at E+LAT+1.
  - One transaction occupies LAT+2 cycles including the IDLE arbitration cycle.
- mem_sel changes only on a grant or on reset. It stays at its last value while idle.
- Request dropped mid-access: the access still completes and done still pulses. This is the requester's protocol error; the arbiter does not abort.
- Request still high in the IDLE cycle after done: treated as a new request. Requesters must drop req on the edge where done is seen.
- we1 changing after grant is ignored.
- Starvation: with both requests held continuously, grants strictly alternate 0,1,0,1...
- LAT=1: ACCESS lasts exactly one cycle.
- Counter width: 8 bits; no wrap, because the count is reloaded only at grant.

Test Plan:
1. Reset: assert rst for 2 cycles from arbitrary state → all outputs 0, busy=0. After release, a tie on req0/req1 grants requester 0 first.
2. Single read, LAT=2: req0=1 at edge 0 → mem_sel=0, mem_en=1 in cycles 1–2, done0=1 in cycle 3 only, busy=0 in cycle 4, done1 never asserts.
3. Write, LAT=2: req1=1, we1=1 at edge 0, we1 dropped at cycle 1 → mem_sel=1, mem_we=1 for the whole access (cycles 1–2), done1 pulses in cycle 3.
4. Contention, LAT=3: req0 and req1 held high continuously → grant order 0,1,0,1. Each done pulse is 5 cycles apart, mem_sel toggles on each grant, and neither done fires twice in a row.
5. Mid-access reset, LAT=4: req1 granted, rst=1 on the 2nd ACCESS cycle → next cycle mem_en=0, no done1, state IDLE. After release, a tie grants 0.
6. Req dropped mid-access, LAT=2: req0 drops in cycle 1 → access completes, done0 still pulses in cycle 3, then IDLE with no new grant.
